// File: rtl/spike_sum_window.sv
// spike_sum_window: saturating accumulator over windows of N accepted samples.
// Each window's signed sum is presented on a valid/ready port that feeds the
// int16-to-fp16 converter, together with a per-window saturation flag.
// Optional feature macro: SPIKE_SUM_OVERLAP_EN, which keeps accumulating the
// next window while a result is held, giving one sample per cycle throughput.
module spike_sum_window #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    input  logic              out_ready
);

    localparam logic [DATA_W-1:0] SUM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SUM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sat_q;
    logic [CNT_W-1:0]  len_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sat_q;

    logic [DATA_W:0]   sum_w;
    logic              clamp_now;
    logic [DATA_W-1:0] acc_d;
    logic              sat_d;
    logic [CNT_W-1:0]  len_eff;
    logic              last_sample;
    logic              in_xfer;
    logic              out_xfer;

    // Saturating add, and the length that applies to the sample now on the input.
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        sum_w     = {acc_q[DATA_W-1], acc_q} + {in_data[DATA_W-1], in_data};
        clamp_now = sum_w[DATA_W] ^ sum_w[DATA_W-1];
        acc_d     = sum_w[DATA_W-1:0];
        if (clamp_now) begin
            acc_d = sum_w[DATA_W] ? SUM_MIN : SUM_MAX;
        end
        sat_d = sat_q | clamp_now;
        // The first sample of a window uses win_len directly: len_q is latched on that edge.
        len_eff = len_q;
        if (cnt_q == '0) begin
            len_eff = (win_len == '0) ? CNT_W'(1) : win_len;
        end
        last_sample = (cnt_q == len_eff - CNT_W'(1));
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

`ifdef SPIKE_SUM_OVERLAP_EN

    // Only the final sample of a window stalls, and only while the previous result is unaccepted.
    assign in_ready = !rst && !(out_valid_q && !out_ready && last_sample);

    // Accumulator and output register; a completing window may reload the output on a transfer edge.
    // NOTE: sequential state uses non-blocking assignments; a later assignment in the block wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            len_q       <= CNT_W'(1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
            if (in_xfer) begin
                if (cnt_q == '0) begin
                    len_q <= len_eff;
                end
                if (last_sample) begin
                    out_data_q  <= acc_d;
                    out_sat_q   <= sat_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    sat_q       <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    sat_q <= sat_d;
                end
            end
        end
    end

`else

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t state_q;

    // Input is accepted only while accumulating; HOLD inserts one bubble per window.
    assign in_ready = !rst && (state_q == ST_ACC);

    // Window FSM: accumulate samples, then hold the result until downstream takes it.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            len_q       <= CNT_W'(1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_xfer) begin
                        if (cnt_q == '0) begin
                            len_q <= len_eff;
                        end
                        if (last_sample) begin
                            out_data_q  <= acc_d;
                            out_sat_q   <= sat_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            sat_q       <= 1'b0;
                            state_q     <= ST_HOLD;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                            sat_q <= sat_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_spike_sum_window.sv
// Testbench for spike_sum_window: directed scenarios plus a randomized run,
// with a scoreboard of expected window results checked on every output transfer.
module tb_spike_sum_window;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [7:0]  win_len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_ready;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    spike_sum_window #(.DATA_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input logic [15:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sb.push_back(e);
    endtask

    // Present one sample and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [15:0] s);
        int  n;
        logic taken;
        n = 0;
        taken = 1'b0;
        in_valid = 1'b1;
        in_data  = s;
        while (!taken && n < 50) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!taken) begin
            failures++;
            $display("FAIL send_timeout: sample %h not accepted, in_ready=%b required 1", s, in_ready);
        end
    endtask

    // Wait for all expected results to be consumed (bounded).
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #7;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 16'h0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b ready=%b data=%h sat=%b required 0 0 0000 0",
                     out_valid, in_ready, out_data, out_sat);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        win_len = 8'd4;
        push(16'd100, 1'b0);
        send(16'd10);
        send(16'd20);
        send(16'd30);
        send(16'd40);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0064) begin
            failures++;
            $display("FAIL basic_latency: valid=%b data=%h required 1 0064", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        drain("basic");
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        win_len = 8'd2;
        push(16'h7FFF, 1'b1);
        push(16'h8000, 1'b1);
        push(16'h0002, 1'b0);
        send(16'd20000);
        send(16'd20000);
        send(-16'sd20000);
        send(-16'sd20000);
        send(16'd5);
        send(-16'sd3);
        drain("saturation");
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        win_len   = 8'd3;
        out_ready = 1'b0;
        push(16'd6, 1'b0);
        send(16'd1);
        send(16'd2);
        send(16'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
`ifdef SPIKE_SUM_OVERLAP_EN
            if (out_valid !== 1'b1 || out_data !== 16'd6 || in_ready !== 1'b1) begin
`else
            if (out_valid !== 1'b1 || out_data !== 16'd6 || in_ready !== 1'b0) begin
`endif
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h in_ready=%b", i, out_valid, out_data, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        drain("backpressure");
        @(posedge clk);
        #1;
    endtask

    task automatic test_len_zero();
        win_len = 8'd0;
        push(16'hFF85, 1'b0);
        push(16'h007B, 1'b0);
        send(-16'sd123);
        send(16'd123);
        drain("len_zero");
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear();
        win_len = 8'd4;
        send(16'd7);
        send(16'd7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd100;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_state: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        push(16'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(16'd1);
        drain("clear");
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        win_len = 8'd4;
        send(16'd9);
        send(16'd9);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(16'd10, 1'b0);
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        drain("reset_mid");
        @(posedge clk);
        #1;
    endtask

    task automatic test_throughput();
        time t0;
        time elapsed;
        win_len = 8'd1;
        for (int i = 0; i < 8; i++) push(16'(i * 3 + 1), 1'b0);
        t0 = $time;
        for (int i = 0; i < 8; i++) send(16'(i * 3 + 1));
        elapsed = $time - t0;
        checks++;
`ifdef SPIKE_SUM_OVERLAP_EN
        if (elapsed != 80) begin
`else
        if (elapsed != 150) begin
`endif
            failures++;
            $display("FAIL throughput: elapsed=%0t for 8 single-sample windows", elapsed);
        end
        drain("throughput");
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [15:0] s;
        int          len;
        int          acc;
        logic        sat;
        for (int w = 0; w < 20; w++) begin
            len     = $urandom_range(1, 5);
            win_len = 8'(len);
            acc     = 0;
            sat     = 1'b0;
            for (int i = 0; i < len; i++) begin
                s = 16'($urandom_range(0, 65535));
                if (clamp16(acc + int'($signed(s))) != acc + int'($signed(s))) sat = 1'b1;
                acc = clamp16(acc + int'($signed(s)));
                if (i == len - 1) push(16'(acc), sat);
                send(s);
            end
        end
        drain("random");
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        win_len   = 8'd1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;

        // Scoreboard monitor: every output transfer must match the oldest expected result.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: data=%h sat=%b with no result expected", out_data, out_sat);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.data || out_sat !== e.sat) begin
                            failures++;
                            $display("FAIL window_result: data=%h sat=%b required %h %b",
                                     out_data, out_sat, e.data, e.sat);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_len_zero();
        test_clear();
        test_reset_mid();
        test_throughput();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_sum_window.md
Name: spike_sum_window

Overview:
- Upstream feeder for the int16-to-fp16 conversion stage.
- Accumulates a stream of signed 16-bit synaptic contributions over a programmable window of N accepted samples, with saturating arithmetic.
- Presents each window's signed 16-bit sum on a valid/ready output port; out_data connects directly to the converter's int_val input.
- Holds the result under backpressure and reports whether saturation occurred in that window.

Parameters:
- DATA_W, 16, sample and sum width (two's complement); the converter requires 16.
- CNT_W, 8, width of the window length and sample counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous flush of the window in progress and the output register.
- win_len  input  CNT_W  samples per window, unsigned; 0 is treated as 1.
- in_valid  input  1  input sample valid.
- in_data  input  DATA_W  signed input sample.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  window sum available.
- out_data  output  DATA_W  signed saturated window sum.
- out_sat  output  1  saturation occurred in this window; qualified by out_valid.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset (rst=1, async): state=ACC, acc=0, cnt=0, sat=0, out_valid=0, out_data=0, out_sat=0, len_q=1. in_ready is 1 once rst deasserts.
- Input transfer: in_valid && in_ready on a rising edge.
- Output transfer: out_valid && out_ready on a rising edge.
- Length latch: len_q <= max(win_len,1) when the first sample of a window is accepted (cnt==0). win_len changes mid-window are ignored until the next window.
- Arithmetic: sum17 = sext(acc) + sext(in_data).
  - Clamp: >32767 gives 32767; <-32768 gives -32768; otherwise sum17[15:0].
  - Any clamp sets the sticky sat bit for the current window.
  - After a clamp, accumulation continues from the clamped value.
- State ACC: in_ready=1. On each input transfer, acc <= clamp(sum17) and cnt <= cnt+1.
  - When the accepted sample is number len_q of the window: out_data <= clamp(sum17), out_sat <= sat | clamp_now, out_valid <= 1. Then acc, cnt and sat are cleared and the state goes to HOLD.
  - Latency: out_valid rises on the edge that accepts the last sample and is visible the following cycle.
- State HOLD: in_ready=0. out_data and out_sat are stable while out_valid=1 && out_ready=0.
  - On output transfer: out_valid <= 0, state goes to ACC.
  - in_ready returns to 1 the cycle after the transfer, so there is one bubble per window.
- win_len=0 or 1: each accepted sample becomes its own window, giving at most one result every 2 cycles.
- clear=1 (sync; priority over all events except rst):
  - acc=0, cnt=0, sat=0, out_valid=0, state=ACC.
  - A sample presented that cycle is dropped, and a pending output is discarded.
  - out_data keeps its old value but is unqualified.
- rst asserted mid-window or during HOLD: immediate return to reset values. Partial sums are lost.
- in_ready has no combinational dependency on in_valid. It depends combinationally on out_ready only when SPIKE_SUM_OVERLAP_EN is defined.

Optional Feature:
- Macro: SPIKE_SUM_OVERLAP_EN.
- Defined: accumulation of the next window continues while a result is held.
  - in_ready = !(out_valid && !out_ready && cnt==len_q-1). The final sample of window k+1 stalls only while window k is still unaccepted.
  - A window completing on the same edge as an output transfer loads the output register directly, so out_valid stays 1.
  - This gives full throughput (one sample per cycle) when out_ready=1.
- Undefined: HOLD behaviour as above, with in_ready=0 while out_valid=1.

Test Plan:
- win_len=4; samples 10,20,30,40 back-to-back; out_ready=1.
  - Required: out_data=100 (0x0064), out_sat=0, out_valid high exactly 1 cycle, starting 1 cycle after the 4th sample.
- win_len=2; samples 20000,20000.
  - Required: out_data=32767 (0x7FFF), out_sat=1.
  - Next window -20000,-20000 gives out_data=-32768 (0x8000), out_sat=1.
  - Next window 5,-3 gives out_data=2, out_sat=0 (sticky bit cleared per window).
- win_len=3; samples 1,2,3; out_ready=0 for 5 cycles then 1.
  - Required: out_data=6 held stable with out_valid=1 throughout, in_ready=0 (feature off).
  - Transfer occurs on the first out_ready=1 cycle; in_ready=1 on the next cycle.
- win_len=0; samples -123, 123.
  - Required: two results, 0xFF85 then 0x007B, each a separate window.
- win_len=4; samples 7,7 then clear pulse; then 1,1,1,1.
  - Required: single result out_data=4; no output for the flushed partial window.
- win_len=4; samples 9,9 then rst pulse asynchronous to clk.
  - Required: out_valid=0 and in_ready=0 immediately while rst is high; the next 4 samples sum from 0.
  - With SPIKE_SUM_OVERLAP_EN: win_len=1 continuous stream with out_ready=1 gives one result per cycle.
